writeback_sequencer: RTL and testbench
======================================

# writeback_sequencer

Collects execution-unit results for the even and odd pipes, aligns them to a fixed write-back stage, and drives the 143-bit write-back packets consumed by the register file (`wrt_back_arr_ep`, `wrt_back_arr_op`). Each pipe is a shift register of in-flight result packets. A unit injects its packet at the stage matching its latency, and the packet exits at the last stage as the write-back packet. The block also provides a forwarding lookup over all in-flight entries and resolves same-cycle, same-address write-back conflicts.

## Interface
Parameters:
- `NUM_STAGES`, 7: write-back pipeline depth; the last stage drives the output.
- `DATA_W`, 128: result width.
- `ADDR_W`, 7: register address width.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all stages.
- `res_ep_valid`  in  1  even-pipe result inject strobe.
- `res_ep_unit`  in  3  even-pipe unit id.
- `res_ep_rt`  in  `ADDR_W`  even-pipe destination register.
- `res_ep_data`  in  `DATA_W`  even-pipe result.
- `res_ep_wr`  in  1  even-pipe result writes the register file.
- `res_ep_lat`  in  4  even-pipe injection stage; legal range 1..`NUM_STAGES`.
- `res_op_*`  in  same widths  odd-pipe equivalents of the six `res_ep_*` ports.
- `flush`  in  1  kills entries in stages 1..`NUM_STAGES`-1 of both pipes.
- `fwd_addr`  in  `ADDR_W`  forwarding lookup address.
- `fwd_hit`  out  1  a valid in-flight entry with wr=1 matches `fwd_addr`.
- `fwd_data`  out  `DATA_W`  data of the youngest match; 0 when there is no hit.
- `wrt_back_arr_ep`  out  [0:142]  even write-back packet.
- `wrt_back_arr_op`  out  [0:142]  odd write-back packet.
- `collision`  out  2  sticky structural-hazard flags, bit 0 even pipe, bit 1 odd pipe.

## Operation
- Packet format [0:142]:
  - [0:2] unit id
  - [3:130] data
  - [131] write enable
  - [132:138] rt address
  - [139:142] latency
- Injection: on a clock edge with `res_xx_valid`=1 and lat L in range, the packet is written into stage L. Out-of-range L (0 or >`NUM_STAGES`) is ignored and sets the collision bit.
- Shift: every cycle stage k moves to stage k+1 for k=1..`NUM_STAGES`-1. Stage 1 receives an empty packet unless an injection targets it.
- Collision: if stage L-1 holds a valid entry in the same cycle as an injection at L, the older (shifting) entry wins. The injected packet is dropped and the collision bit sets. The bit is cleared only by reset.
- Output: stage `NUM_STAGES` is the write-back packet. An empty stage outputs all zeros, so bit 131 is 0.
- Same-address conflict: if both output stages have wr=1 with equal rt, the odd packet writes. Bit 131 of `wrt_back_arr_ep` is forced to 0; all other ep fields are unchanged.
- Flush: at the edge, stages 1..`NUM_STAGES`-1 of both pipes become empty; the last stage is unaffected. An injection in the same cycle as flush is also discarded, and no collision is flagged.
- Forwarding (combinational over registered stages): the youngest entry (lowest stage index) wins. At an equal stage, odd wins over even. Only entries with wr=1 can hit.

## Timing
- Reset: all stages empty; both packets 0; `fwd_hit`=0; `fwd_data`=0; `collision`=0.
- Inject with lat L on edge t: the packet appears on the output `NUM_STAGES`-L+1 edges later (lat 7: one edge; lat 1: seven edges). The register file commits it on the following edge.
- Forwarding reflects state after an edge; there is no same-cycle bypass of the `res_*` inputs.
- Reset assertion mid-flight empties all stages immediately, independent of the clock.

## Structure
- Shared package `wb_pkg`: packet field bit-index constants, packet width 143, `NUM_STAGES`, a unit-id enum, and an empty-packet constant.
- One sub-module, `wb_pipe`: a single pipe's shift register with injection and collision logic, instantiated twice.
- Top level holds the conflict resolution and the forwarding priority mux.

## Test plan
- Even-pipe inject, rt=5, data=0xA5…A5, wr=1, lat=7 → next cycle `wrt_back_arr_ep`[131]=1, [132:138]=5, data matches; the cycle after that, the packet is 0.
- Odd-pipe inject lat=1, rt=9 → packet appears exactly 7 edges later; `fwd_hit`=1 for `fwd_addr`=9 on each of the 7 cycles the entry is in flight.
- Even lat=3 at cycle t, then even lat=4 at t+1 → the lat=4 packet is dropped; `collision`=2'b01; only the first packet is written back.
- Both pipes reach the output with rt=12 in the same cycle → ep[131]=0, op[131]=1 with odd data.
- Two entries in flight for rt=20 (stages 2 and 5) → `fwd_data` equals the stage-2 data; flush → `fwd_hit`=0 and nothing is written back.
- Assert `reset` low mid-flight → outputs drop to 0 immediately; after release, no stale packet appears.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_pkg                                                    |
// | Desc     : Shared types and constants for the write-back sequencer:  |
// |            packet field positions, in-flight entry struct, unit ids. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int NUM_STAGES = 7;
  localparam int PKT_DATA_W = 128;
  localparam int PKT_ADDR_W = 7;
  localparam int UNIT_W     = 3;
  localparam int LAT_W      = 4;
  localparam int PKT_W      = 143;

  // Field positions inside the big-endian [0:142] write-back packet
  localparam int UNIT_MSB = 0;
  localparam int UNIT_LSB = 2;
  localparam int DATA_MSB = 3;
  localparam int DATA_LSB = 130;
  localparam int WR_BIT   = 131;
  localparam int RT_MSB   = 132;
  localparam int RT_LSB   = 138;
  localparam int LAT_MSB  = 139;
  localparam int LAT_LSB  = 142;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_FX1  = 3'd0,
    UNIT_FX2  = 3'd1,
    UNIT_BYTE = 3'd2,
    UNIT_SFP  = 3'd3,
    UNIT_FP   = 3'd4,
    UNIT_PERM = 3'd5,
    UNIT_LS   = 3'd6,
    UNIT_BR   = 3'd7
  } unit_e;

  typedef logic [0:PKT_W-1] wb_pkt_t;

  typedef struct packed {
    unit_e                 unit;
    logic [PKT_DATA_W-1:0] data;
    logic                  wr;
    logic [PKT_ADDR_W-1:0] rt;
    logic [LAT_W-1:0]      lat;
  } wb_entry_t;

  localparam wb_pkt_t   EMPTY_PKT   = '0;
  localparam wb_entry_t EMPTY_ENTRY = '0;

  // Place each entry field at its fixed position in the outgoing packet
  function automatic wb_pkt_t pack_entry(input wb_entry_t e);
    wb_pkt_t p;
    p                    = EMPTY_PKT;
    p[UNIT_MSB:UNIT_LSB] = e.unit;
    p[DATA_MSB:DATA_LSB] = e.data;
    p[WR_BIT]            = e.wr;
    p[RT_MSB:RT_LSB]     = e.rt;
    p[LAT_MSB:LAT_LSB]   = e.lat;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : writeback_sequencer_if                                    |
// | Desc     : Result-inject, flush, forwarding and write-back bundle.   |
// |            master = execution side, slave = sequencer.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface writeback_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
);

  logic              res_ep_valid;
  logic [2:0]        res_ep_unit;
  logic [ADDR_W-1:0] res_ep_rt;
  logic [DATA_W-1:0] res_ep_data;
  logic              res_ep_wr;
  logic [3:0]        res_ep_lat;

  logic              res_op_valid;
  logic [2:0]        res_op_unit;
  logic [ADDR_W-1:0] res_op_rt;
  logic [DATA_W-1:0] res_op_data;
  logic              res_op_wr;
  logic [3:0]        res_op_lat;

  logic              flush;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  wb_pkg::wb_pkt_t   wrt_back_arr_ep;
  wb_pkg::wb_pkt_t   wrt_back_arr_op;
  logic [1:0]        collision;

  modport master (
    output res_ep_valid, res_ep_unit, res_ep_rt, res_ep_data, res_ep_wr, res_ep_lat,
    output res_op_valid, res_op_unit, res_op_rt, res_op_data, res_op_wr, res_op_lat,
    output flush, fwd_addr,
    input  fwd_hit, fwd_data, wrt_back_arr_ep, wrt_back_arr_op, collision
  );

  modport slave (
    input  res_ep_valid, res_ep_unit, res_ep_rt, res_ep_data, res_ep_wr, res_ep_lat,
    input  res_op_valid, res_op_unit, res_op_rt, res_op_data, res_op_wr, res_op_lat,
    input  flush, fwd_addr,
    output fwd_hit, fwd_data, wrt_back_arr_ep, wrt_back_arr_op, collision
  );

endinterface
`default_nettype wire

// File: rtl/wb_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_pipe                                                   |
// | Desc     : One write-back pipe: shift register of in-flight results, |
// |            latency-indexed injection, flush and sticky collision.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module wb_pipe #(
  parameter int NUM_STAGES = 7
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  inj_valid,
  input  wb_pkg::wb_entry_t                     inj_entry,
  input  logic                                  flush,
  output wb_pkg::wb_entry_t [NUM_STAGES:1]      stage_entry,
  output logic              [NUM_STAGES:1]      stage_valid,
  output logic                                  collision
);

  import wb_pkg::*;

  wb_entry_t [NUM_STAGES:1] stage_q, stage_d;
  logic      [NUM_STAGES:1] valid_q, valid_d;
  logic                     collision_q, collision_d;
  logic                     lat_in_range;
  logic                     slot_blocked;

  // Injection legality: latency must name a real stage, and an older entry
  // shifting into that stage this edge takes priority over the newcomer
  always_comb begin
    lat_in_range = (inj_entry.lat != '0) && (inj_entry.lat <= LAT_W'(NUM_STAGES));
    slot_blocked = 1'b0;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      if ((inj_entry.lat == LAT_W'(k)) && valid_q[k-1]) begin
        slot_blocked = 1'b1;
      end
    end
  end

  // Next pipe contents: shift by one, then apply flush or injection
  always_comb begin
    stage_d     = '0;
    valid_d     = '0;
    collision_d = collision_q;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
    stage_d[1] = EMPTY_ENTRY;
    valid_d[1] = 1'b0;
    if (flush) begin
      // Killing stages 1..N-1 means nothing moves into the last stage either;
      // the entry already sitting in the last stage is still written back.
      stage_d = '0;
      valid_d = '0;
    end else if (inj_valid) begin
      if (!lat_in_range || slot_blocked) begin
        collision_d = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_STAGES; k++) begin
          if (inj_entry.lat == LAT_W'(k)) begin
            stage_d[k] = inj_entry;
            valid_d[k] = 1'b1;
          end
        end
      end
    end
  end

  // Stage registers and sticky collision flag; reset empties the pipe at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q     <= '0;
      valid_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      valid_q     <= valid_d;
      collision_q <= collision_d;
    end
  end

  assign stage_entry = stage_q;
  assign stage_valid = valid_q;
  assign collision   = collision_q;

endmodule
`default_nettype wire

// File: rtl/writeback_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : writeback_sequencer                                       |
// | Desc     : Even/odd write-back alignment pipes, same-address         |
// |            write-back conflict resolution and forwarding lookup.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module writeback_sequencer #(
  parameter int NUM_STAGES = 7,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  writeback_sequencer_if.slave  bus
);

  import wb_pkg::*;

  // The packet layout is fixed, so widths must match it and lat must fit 4 bits
  generate
    if ((DATA_W != PKT_DATA_W) || (ADDR_W != PKT_ADDR_W) ||
        (NUM_STAGES < 2) || (NUM_STAGES > 15)) begin : g_param_check
      $error("writeback_sequencer: unsupported parameter combination");
    end
  endgenerate

  wb_entry_t                  ep_inj, op_inj;
  wb_entry_t [NUM_STAGES:1]   ep_stage, op_stage;
  logic      [NUM_STAGES:1]   ep_valid, op_valid;
  logic                       ep_collision, op_collision;
  wb_pkt_t                    ep_pkt, op_pkt;
  logic                       wb_conflict;
  logic                       fwd_hit;
  logic      [DATA_W-1:0]     fwd_data;

  // Gather the inject-side fields of each pipe into entry records
  always_comb begin
    ep_inj = '{unit: unit_e'(bus.res_ep_unit), data: bus.res_ep_data,
               wr: bus.res_ep_wr, rt: bus.res_ep_rt, lat: bus.res_ep_lat};
    op_inj = '{unit: unit_e'(bus.res_op_unit), data: bus.res_op_data,
               wr: bus.res_op_wr, rt: bus.res_op_rt, lat: bus.res_op_lat};
  end

  wb_pipe #(.NUM_STAGES(NUM_STAGES)) u_pipe_ep (
    .clock       (clock),
    .reset       (reset),
    .inj_valid   (bus.res_ep_valid),
    .inj_entry   (ep_inj),
    .flush       (bus.flush),
    .stage_entry (ep_stage),
    .stage_valid (ep_valid),
    .collision   (ep_collision)
  );

  wb_pipe #(.NUM_STAGES(NUM_STAGES)) u_pipe_op (
    .clock       (clock),
    .reset       (reset),
    .inj_valid   (bus.res_op_valid),
    .inj_entry   (op_inj),
    .flush       (bus.flush),
    .stage_entry (op_stage),
    .stage_valid (op_valid),
    .collision   (op_collision)
  );

  // Write-back packets; on a same-register clash the odd pipe keeps the write
  always_comb begin
    ep_pkt = ep_valid[NUM_STAGES] ? pack_entry(ep_stage[NUM_STAGES]) : EMPTY_PKT;
    op_pkt = op_valid[NUM_STAGES] ? pack_entry(op_stage[NUM_STAGES]) : EMPTY_PKT;
    wb_conflict = ep_pkt[WR_BIT] && op_pkt[WR_BIT] &&
                  (ep_pkt[RT_MSB:RT_LSB] == op_pkt[RT_MSB:RT_LSB]);
    if (wb_conflict) begin
      ep_pkt[WR_BIT] = 1'b0;
    end
  end

  // Forwarding: scan oldest to youngest so the lowest stage overrides,
  // and within a stage the odd pipe is evaluated last so it wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (ep_valid[k] && ep_stage[k].wr && (ep_stage[k].rt == bus.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ep_stage[k].data;
      end
      if (op_valid[k] && op_stage[k].wr && (op_stage[k].rt == bus.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = op_stage[k].data;
      end
    end
  end

  assign bus.wrt_back_arr_ep = ep_pkt;
  assign bus.wrt_back_arr_op = op_pkt;
  assign bus.fwd_hit         = fwd_hit;
  assign bus.fwd_data        = fwd_data;
  assign bus.collision       = {op_collision, ep_collision};

endmodule
`default_nettype wire

// File: tb/tb_writeback_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_writeback_sequencer                                    |
// | Desc     : Table-driven bench with write-back scoreboard.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_writeback_sequencer;

  localparam int N = 7;

  typedef logic [142:0] w_t;
  typedef struct {
    logic        v;
    logic [3:0]  lat;
    logic [6:0]  rt;
    logic        wr;
    logic [127:0] d;
    logic        acc;
  } inj_t;
  typedef struct {
    inj_t        ep;
    inj_t        op;
    logic        fl;
    logic [6:0]  fa;
    logic        hit;
    logic [127:0] fd;
    logic [1:0]  coll;
  } vec_t;
  typedef struct {
    int           ext;
    logic [0:142] pkt;
  } sb_t;

  localparam logic [2:0] EP_UNIT = 3'd1;
  localparam logic [2:0] OP_UNIT = 3'd4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  writeback_sequencer_if #(.DATA_W(128), .ADDR_W(7)) bus ();

  writeback_sequencer #(.NUM_STAGES(N), .DATA_W(128), .ADDR_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  sb_t  q_ep[$];
  sb_t  q_op[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;
  logic [0:142] m_ep, m_op;
  inj_t idle_inj;
  vec_t tbl[29];
  logic [127:0] d_a5, d_09, d_c1, d_c2, d_e4, d_p1, d_p2, d_fo, d_fn, d_50, d_51, d_52, d_60, d_61, d_62, z;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic inj_t mi(input logic [3:0] lat, input logic [6:0] rt, input logic wr,
                              input logic [127:0] d, input logic acc);
    inj_t r;
    r.v = 1'b1; r.lat = lat; r.rt = rt; r.wr = wr; r.d = d; r.acc = acc;
    return r;
  endfunction

  function automatic logic [0:142] mk_pkt(input logic [2:0] u, input inj_t i);
    logic [0:142] p;
    p = {u, i.d, i.wr, i.rt, i.lat};
    return p;
  endfunction

  task automatic check(input string name, input w_t act, input w_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic purge(input int lim);
    for (int i = q_ep.size() - 1; i >= 0; i--) if (q_ep[i].ext >= lim) q_ep.delete(i);
    for (int i = q_op.size() - 1; i >= 0; i--) if (q_op[i].ext >= lim) q_op.delete(i);
  endtask

  task automatic drive(input inj_t ep, input inj_t op, input logic fl, input logic [6:0] fa);
    bus.res_ep_valid = ep.v; bus.res_ep_unit = EP_UNIT; bus.res_ep_rt = ep.rt;
    bus.res_ep_data  = ep.d; bus.res_ep_wr   = ep.wr;   bus.res_ep_lat = ep.lat;
    bus.res_op_valid = op.v; bus.res_op_unit = OP_UNIT; bus.res_op_rt = op.rt;
    bus.res_op_data  = op.d; bus.res_op_wr   = op.wr;   bus.res_op_lat = op.lat;
    bus.flush    = fl;
    bus.fwd_addr = fa;
    if (fl) purge(cyc + 1);
    if (ep.v && ep.acc) q_ep.push_back('{ext: cyc + 1 + N - int'(ep.lat), pkt: mk_pkt(EP_UNIT, ep)});
    if (op.v && op.acc) q_op.push_back('{ext: cyc + 1 + N - int'(op.lat), pkt: mk_pkt(OP_UNIT, op)});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    bus.res_ep_valid = 1'b0;
    bus.res_op_valid = 1'b0;
    bus.flush        = 1'b0;
  endtask

  // Scoreboard monitor: pop whatever is due to exit this cycle, else expect zeros
  task automatic monitor_cycle();
    m_ep = '0;
    m_op = '0;
    for (int i = 0; i < q_ep.size(); i++) begin
      if (q_ep[i].ext == cyc) begin m_ep = q_ep[i].pkt; q_ep.delete(i); break; end
    end
    for (int i = 0; i < q_op.size(); i++) begin
      if (q_op[i].ext == cyc) begin m_op = q_op[i].pkt; q_op.delete(i); break; end
    end
    if (m_ep[131] && m_op[131] && (m_ep[132:138] == m_op[132:138])) m_ep[131] = 1'b0;
    check($sformatf("wb_ep@%0d", cyc), bus.wrt_back_arr_ep, m_ep);
    check($sformatf("wb_op@%0d", cyc), bus.wrt_back_arr_op, m_op);
  endtask

  initial forever begin
    @(negedge clock);
    if (mon_en) monitor_cycle();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    d_a5 = {4{32'hA5A5_A5A5}}; d_09 = {4{32'h0909_D00D}}; d_c1 = {4{32'hC1C1_0001}};
    d_c2 = {4{32'hC2C2_0002}}; d_e4 = {4{32'hE0E0_4040}}; d_p1 = {4{32'h1111_2222}};
    d_p2 = {4{32'h3333_4444}}; d_fo = {4{32'hF0F0_0020}}; d_fn = {4{32'h0F0F_2020}};
    d_50 = {4{32'h5050_0050}}; d_51 = {4{32'h5151_0051}}; d_52 = {4{32'h5252_0052}};
    d_60 = {4{32'h6060_0060}}; d_61 = {4{32'h6161_0061}}; d_62 = {4{32'h6262_0062}};
    z = '0;
    idle_inj = '{v: 1'b0, lat: 4'd0, rt: 7'd0, wr: 1'b0, d: '0, acc: 1'b0};

    tbl[0]  = '{mi(4'd7, 7'd5, 1'b1, d_a5, 1'b1), idle_inj, 1'b0, 7'd5, 1'b1, d_a5, 2'b00};
    tbl[1]  = '{idle_inj, idle_inj, 1'b0, 7'd5, 1'b0, z, 2'b00};
    tbl[2]  = '{idle_inj, mi(4'd1, 7'd9, 1'b1, d_09, 1'b1), 1'b0, 7'd9, 1'b1, d_09, 2'b00};
    for (int i = 3; i <= 8; i++) tbl[i] = '{idle_inj, idle_inj, 1'b0, 7'd9, 1'b1, d_09, 2'b00};
    tbl[9]  = '{idle_inj, idle_inj, 1'b0, 7'd9, 1'b0, z, 2'b00};
    tbl[10] = '{mi(4'd3, 7'd30, 1'b1, d_c1, 1'b1), idle_inj, 1'b0, 7'd30, 1'b1, d_c1, 2'b00};
    tbl[11] = '{mi(4'd4, 7'd31, 1'b1, d_c2, 1'b0), idle_inj, 1'b0, 7'd31, 1'b0, z, 2'b01};
    tbl[12] = '{idle_inj, idle_inj, 1'b0, 7'd30, 1'b1, d_c1, 2'b01};
    tbl[13] = '{idle_inj, mi(4'd6, 7'd40, 1'b0, d_e4, 1'b1), 1'b0, 7'd40, 1'b0, z, 2'b01};
    tbl[14] = '{idle_inj, mi(4'd0, 7'd41, 1'b1, d_c2, 1'b0), 1'b0, 7'd30, 1'b1, d_c1, 2'b11};
    tbl[15] = '{mi(4'd9, 7'd42, 1'b1, d_c2, 1'b0), idle_inj, 1'b0, 7'd30, 1'b0, z, 2'b11};
    tbl[16] = '{mi(4'd5, 7'd12, 1'b1, d_p1, 1'b1), mi(4'd5, 7'd12, 1'b1, d_p2, 1'b1),
                1'b0, 7'd12, 1'b1, d_p2, 2'b11};
    tbl[17] = '{idle_inj, idle_inj, 1'b0, 7'd12, 1'b1, d_p2, 2'b11};
    tbl[18] = '{idle_inj, idle_inj, 1'b0, 7'd12, 1'b1, d_p2, 2'b11};
    tbl[19] = '{idle_inj, idle_inj, 1'b0, 7'd12, 1'b0, z, 2'b11};
    tbl[20] = '{idle_inj, mi(4'd2, 7'd20, 1'b1, d_fo, 1'b1), 1'b0, 7'd20, 1'b1, d_fo, 2'b11};
    tbl[21] = '{idle_inj, idle_inj, 1'b0, 7'd20, 1'b1, d_fo, 2'b11};
    tbl[22] = '{idle_inj, idle_inj, 1'b0, 7'd20, 1'b1, d_fo, 2'b11};
    tbl[23] = '{mi(4'd2, 7'd20, 1'b1, d_fn, 1'b1), idle_inj, 1'b0, 7'd20, 1'b1, d_fn, 2'b11};
    tbl[24] = '{idle_inj, idle_inj, 1'b1, 7'd20, 1'b0, z, 2'b11};
    for (int i = 25; i <= 28; i++) tbl[i] = '{idle_inj, idle_inj, 1'b0, 7'd20, 1'b0, z, 2'b11};

    // Reset state
    drive(idle_inj, idle_inj, 1'b0, 7'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_wb_ep", bus.wrt_back_arr_ep, '0);
    check("rst_wb_op", bus.wrt_back_arr_op, '0);
    check("rst_fwd_hit", w_t'(bus.fwd_hit), '0);
    check("rst_fwd_data", w_t'(bus.fwd_data), '0);
    check("rst_collision", w_t'(bus.collision), '0);
    @(posedge clock);
    #3;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Table-driven vectors
    foreach (tbl[i]) begin
      drive(tbl[i].ep, tbl[i].op, tbl[i].fl, tbl[i].fa);
      step();
      check($sformatf("fwd_hit[%0d]", i), w_t'(bus.fwd_hit), w_t'(tbl[i].hit));
      check($sformatf("fwd_data[%0d]", i), w_t'(bus.fwd_data), w_t'(tbl[i].fd));
      check($sformatf("collision[%0d]", i), w_t'(bus.collision), w_t'(tbl[i].coll));
    end

    // Asynchronous reset in the middle of traffic
    drive(mi(4'd1, 7'd50, 1'b1, d_50, 1'b1), mi(4'd3, 7'd51, 1'b1, d_51, 1'b1), 1'b0, 7'd50);
    step();
    drive(idle_inj, idle_inj, 1'b0, 7'd50);
    step();
    drive(mi(4'd7, 7'd52, 1'b1, d_52, 1'b1), idle_inj, 1'b0, 7'd50);
    step();
    check("pre_rst_fwd_hit", w_t'(bus.fwd_hit), w_t'(1'b1));
    check("pre_rst_wb_ep", bus.wrt_back_arr_ep, mk_pkt(EP_UNIT, mi(4'd7, 7'd52, 1'b1, d_52, 1'b1)));
    #2;
    reset = 1'b0;
    q_ep.delete();
    q_op.delete();
    #1;
    check("mid_rst_wb_ep", bus.wrt_back_arr_ep, '0);
    check("mid_rst_wb_op", bus.wrt_back_arr_op, '0);
    check("mid_rst_fwd_hit", w_t'(bus.fwd_hit), '0);
    check("mid_rst_collision", w_t'(bus.collision), '0);
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    repeat (9) step();

    // Flush with simultaneous injections: discarded, no collision flagged
    drive(mi(4'd4, 7'd60, 1'b1, d_60, 1'b1), idle_inj, 1'b0, 7'd60);
    step();
    check("pre_flush_fwd_hit", w_t'(bus.fwd_hit), w_t'(1'b1));
    drive(mi(4'd5, 7'd61, 1'b1, d_61, 1'b0), mi(4'd3, 7'd62, 1'b1, d_62, 1'b0), 1'b1, 7'd60);
    step();
    check("flush_collision", w_t'(bus.collision), '0);
    check("flush_fwd_hit60", w_t'(bus.fwd_hit), '0);
    bus.fwd_addr = 7'd61;
    #1;
    check("flush_fwd_hit61", w_t'(bus.fwd_hit), '0);
    repeat (9) step();

    check("sb_ep_drained", w_t'(q_ep.size()), '0);
    check("sb_op_drained", w_t'(q_op.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
